cic_int_dec: RTL

Integrator-and-decimator front half of the CIC decimation filter. It accumulates the input stream through `Ncomb` cascaded integrators and keeps one of every `R` valid samples. Its output feeds `cic_comb`, which is instantiated with `W = Win + Ng`. Data is signed two's-complement and arithmetic wraps modulo 2^(Win+Ng), which the comb section relies on.

---
 rtl/cic_pkg.sv | 18 +
 rtl/cic_integ.sv | 36 +++
 rtl/cic_int_dec.sv | 94 +++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator: default widths,
// stage count, decimation factor and the full-precision word type.
package cic_pkg;

   localparam int Win   = 16;
   localparam int Ncomb = 3;
   localparam int R     = 8;
   localparam int Ng    = Ncomb * $clog2(R);
   localparam int W     = Win + Ng;

   typedef logic signed [W-1:0] cic_word_t;

   // Phase counter width; R=1 still needs a one-bit counter to exist.
   function automatic int cnt_width(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

endpackage

// File: rtl/cic_integ.sv
// Single integrator stage: a W-bit wrapping accumulator that adds its input
// on every enabled edge and clears on synchronous reset.
module cic_integ #(
   parameter int W = cic_pkg::W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic signed [W-1:0] add_in,
   output logic signed [W-1:0] acc_out
);
   import cic_pkg::*;

   logic signed [W-1:0] acc_d;
   logic signed [W-1:0] acc_q;

   // Next accumulator value: add on enable, otherwise hold; wraps modulo 2^W.
   always_comb begin
      acc_d = acc_q;
      if (en) begin
         acc_d = acc_q + add_in;
      end
   end

   // Accumulator register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_out = acc_q;

endmodule

// File: rtl/cic_int_dec.sv
// Integrator cascade plus decimator for the CIC decimation filter. Ncomb
// pipelined integrators run on every valid input; one of every R valid
// samples is latched into the output register with a one-cycle strobe.
module cic_int_dec #(
   parameter int Win   = cic_pkg::Win,
   parameter int Ncomb = cic_pkg::Ncomb,
   parameter int R     = cic_pkg::R,
   parameter int Ng    = Ncomb * $clog2(R)
) (
   input  logic                     clk,
   input  logic                     ic_rst,
   input  logic signed [Win-1:0]    id_data,
   input  logic                     ic_val_data,
   output logic signed [Win+Ng-1:0] od_data,
   output logic                     oc_val_data
);
   import cic_pkg::*;

   localparam int W    = Win + Ng;
   localparam int CntW = cnt_width(R);
   localparam logic [CntW-1:0] LastPhase = CntW'(R - 1);

   logic signed [W-1:0] stage_in  [Ncomb];
   logic signed [W-1:0] stage_acc [Ncomb];
   logic signed [W-1:0] last_next;

   logic [CntW-1:0]     cnt_d;
   logic [CntW-1:0]     cnt_q;
   logic signed [W-1:0] od_d;
   logic signed [W-1:0] od_q;
   logic                oc_d;
   logic                oc_q;

   // Stage inputs: first stage takes the sign-extended sample, later stages
   // take the previous stage's registered value, giving the pipelined cascade.
   always_comb begin
      stage_in[0] = W'(id_data);
      for (int i = 1; i < Ncomb; i++) begin
         stage_in[i] = stage_acc[i-1];
      end
   end

   genvar k;
   generate
      for (k = 0; k < Ncomb; k++) begin : g_stage
         cic_integ #(
            .W(W)
         ) u_integ (
            .clk    (clk),
            .rst    (ic_rst),
            .en     (ic_val_data),
            .add_in (stage_in[k]),
            .acc_out(stage_acc[k])
         );
      end
   endgenerate

   // Value the last integrator takes at this edge, so the output carries the
   // post-update sum without an extra cycle of latency.
   assign last_next = stage_acc[Ncomb-1] + stage_in[Ncomb-1];

   // Decimation phase: on the R-th valid sample latch the output and strobe.
   always_comb begin
      cnt_d = cnt_q;
      od_d  = od_q;
      oc_d  = 1'b0;
      if (ic_val_data) begin
         if (cnt_q == LastPhase) begin
            cnt_d = '0;
            od_d  = last_next;
            oc_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Phase counter and output registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (ic_rst) begin
         cnt_q <= '0;
         od_q  <= '0;
         oc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         od_q  <= od_d;
         oc_q  <= oc_d;
      end
   end

   assign od_data     = od_q;
   assign oc_val_data = oc_q;

endmodule
